// File: rtl/gates7_dataflow_if.sv
// Operand/result bundle for the seven-gate logic unit, its sample counter and optional register bank.
// Master drives operands and the sample strobe; slave returns gate results, count and registered bank.
interface gates7_dataflow_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic                 en;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     f_and;
    logic [WIDTH-1:0]     f_or;
    logic [WIDTH-1:0]     f_not;
    logic [WIDTH-1:0]     f_nand;
    logic [WIDTH-1:0]     f_nor;
    logic [WIDTH-1:0]     f_xor;
    logic [WIDTH-1:0]     f_xnor;
    logic [CNT_W-1:0]     smp_cnt;
    logic                 r_valid;
    logic [7*WIDTH-1:0]   r_func;

    modport master (
        output en, a, b,
        input  f_and, f_or, f_not, f_nand, f_nor, f_xor, f_xnor,
        input  smp_cnt, r_valid, r_func
    );

    modport slave (
        input  en, a, b,
        output f_and, f_or, f_not, f_nand, f_nor, f_xor, f_xnor,
        output smp_cnt, r_valid, r_func
    );
endinterface

// File: rtl/gates7_dataflow.sv
// Seven bitwise gates (zero latency) plus saturating sample counter; no backpressure, en qualifies samples.
// Define GATES7_DATAFLOW_REG_BANK_EN to add a 1-cycle registered copy of all gate results (r_func/r_valid).
module gates7_dataflow #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    gates7_dataflow_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    assign bus.f_and  = bus.a & bus.b;
    assign bus.f_or   = bus.a | bus.b;
    assign bus.f_not  = ~bus.a;
    assign bus.f_nand = ~(bus.a & bus.b);
    assign bus.f_nor  = ~(bus.a | bus.b);
    assign bus.f_xor  = bus.a ^ bus.b;
    assign bus.f_xnor = ~(bus.a ^ bus.b);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter sticks at all-ones rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.smp_cnt = cnt_q;

`ifdef GATES7_DATAFLOW_REG_BANK_EN
    logic [7*WIDTH-1:0] func_q;
    logic [7*WIDTH-1:0] func_d;
    logic               valid_q;
    logic               valid_d;

    always_comb begin
        func_d  = func_q;
        valid_d = valid_q;
        if (bus.en) begin
            func_d  = {bus.f_xnor, bus.f_xor, bus.f_nor, bus.f_nand,
                       bus.f_not, bus.f_or, bus.f_and};
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            func_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            func_q  <= func_d;
            valid_q <= valid_d;
        end
    end

    assign bus.r_func  = func_q;
    assign bus.r_valid = valid_q;
`else
    assign bus.r_func  = '0;
    assign bus.r_valid = 1'b0;
`endif
endmodule

// File: tb/tb_gates7_dataflow.sv
// Scoreboard bench: WIDTH=1/CNT_W=2 instance for truth table, counter, reset and bank; WIDTH=4 for vectors.
module tb_gates7_dataflow;
`ifdef GATES7_DATAFLOW_REG_BANK_EN
    localparam bit BANK_ON = 1'b1;
`else
    localparam bit BANK_ON = 1'b0;
`endif

    logic clk;
    logic rst;

    gates7_dataflow_if #(.WIDTH(1), .CNT_W(2)) bus1 ();
    gates7_dataflow_if #(.WIDTH(4), .CNT_W(8)) bus4 ();

    gates7_dataflow #(.WIDTH(1), .CNT_W(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    gates7_dataflow #(.WIDTH(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] sb_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] pack1();
        return 32'({bus1.f_xnor, bus1.f_xor, bus1.f_nor, bus1.f_nand,
                    bus1.f_not, bus1.f_or, bus1.f_and});
    endfunction

    function automatic logic [31:0] pack4();
        return 32'({bus4.f_xnor, bus4.f_xor, bus4.f_nor, bus4.f_nand,
                    bus4.f_not, bus4.f_or, bus4.f_and});
    endfunction

    function automatic logic [27:0] model4(input logic [3:0] x, input logic [3:0] y);
        logic [27:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i]      = x[i] & y[i];
            r[4 + i]  = x[i] | y[i];
            r[8 + i]  = !x[i];
            r[12 + i] = !(x[i] & y[i]);
            r[16 + i] = !(x[i] | y[i]);
            r[20 + i] = x[i] != y[i];
            r[24 + i] = x[i] == y[i];
        end
        return r;
    endfunction

    // Truth-table rows: {a, b, expected {xnor,xor,nor,nand,not,or,and}}
    logic [8:0] tt [5] = '{
        {1'b0, 1'b0, 7'b1011100},
        {1'b1, 1'b0, 7'b0101010},
        {1'b0, 1'b1, 7'b0101110},
        {1'b1, 1'b1, 7'b1000011},
        {1'b0, 1'b0, 7'b1011100}
    };

    int unsigned cnt_m;
    logic [8:0]  row;
    logic [3:0]  ra;
    logic [3:0]  rb;

    initial begin
        rst = 1'b1;
        bus1.en = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0;
        bus4.en = 1'b0; bus4.a = 4'd0; bus4.b = 4'd0;
        #12;
        rst = 1'b0;
        #1;

        // Reset state
        check_val("rst_cnt1",   32'(bus1.smp_cnt), 32'd0);
        check_val("rst_cnt4",   32'(bus4.smp_cnt), 32'd0);
        check_val("rst_rvalid", 32'(bus1.r_valid), 32'd0);
        check_val("rst_rfunc",  32'(bus1.r_func),  32'd0);

        // WIDTH=1 truth table, each row held one time unit
        for (int i = 0; i < 5; i++) begin
            row = tt[i];
            bus1.a = row[8];
            bus1.b = row[7];
            sb_q.push_back(32'(row[6:0]));
            #1;
            check_val($sformatf("tt%0d", i), pack1(), sb_q.pop_front());
        end

        // WIDTH=4 fixed vector then random vectors
        bus4.a = 4'b1100;
        bus4.b = 4'b1010;
        sb_q.push_back(32'({4'b1001, 4'b0110, 4'b0001, 4'b0111, 4'b0011, 4'b1110, 4'b1000}));
        #1;
        check_val("w4_fixed", pack4(), sb_q.pop_front());
        for (int i = 0; i < 8; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            bus4.a = ra;
            bus4.b = rb;
            sb_q.push_back(32'(model4(ra, rb)));
            #1;
            check_val($sformatf("w4_rand%0d", i), pack4(), sb_q.pop_front());
        end

        // Saturating counter, CNT_W=2
        cnt_m = 0;
        @(negedge clk);
        bus1.en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (cnt_m < 3) cnt_m++;
            sb_q.push_back(32'(cnt_m));
            check_val($sformatf("cnt_en%0d", i), 32'(bus1.smp_cnt), sb_q.pop_front());
        end
        @(negedge clk);
        bus1.en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            sb_q.push_back(32'(cnt_m));
            check_val($sformatf("cnt_hold%0d", i), 32'(bus1.smp_cnt), sb_q.pop_front());
        end

        // Asynchronous reset between edges
        @(negedge clk);
        bus1.a = 1'b1;
        bus1.b = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check_val("arst_cnt", 32'(bus1.smp_cnt), 32'd0);
        check_val("arst_func", pack1(), 32'(7'b1000011));
        check_val("arst_rvalid", 32'(bus1.r_valid), 32'd0);
        // Reset release coincident with an edge while en=1: that edge must not capture
        bus1.a = 1'b1;
        bus1.b = 1'b0;
        bus1.en = 1'b1;
        @(posedge clk);
        rst <= 1'b0;
        #1;
        check_val("rel_cnt", 32'(bus1.smp_cnt), 32'd0);
        check_val("rel_rvalid", 32'(bus1.r_valid), 32'd0);
        @(posedge clk);
        #1;
        check_val("cap_cnt", 32'(bus1.smp_cnt), 32'd1);
        check_val("cap_rvalid", 32'(bus1.r_valid), BANK_ON ? 32'd1 : 32'd0);
        check_val("cap_rfunc", 32'(bus1.r_func), BANK_ON ? 32'(7'b0101010) : 32'd0);

        // en=0: bank holds despite new operands
        @(negedge clk);
        bus1.en = 1'b0;
        bus1.a = 1'b0;
        bus1.b = 1'b0;
        @(posedge clk);
        #1;
        check_val("hold_cnt", 32'(bus1.smp_cnt), 32'd1);
        check_val("hold_rvalid", 32'(bus1.r_valid), BANK_ON ? 32'd1 : 32'd0);
        check_val("hold_rfunc", 32'(bus1.r_func), BANK_ON ? 32'(7'b0101010) : 32'd0);

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
